rll_key_loader: RTL

- Key-delivery stage that sits directly upstream of the RLL16 locked netlists.
- Receives the 16-bit unlock key over a 1-bit valid/ready serial stream and checks an even-parity bit.
- Commits the key atomically to a held register; bit i of the register drives keyIn_0_i of the locked core.
- The locked core never sees a partially shifted key; key_q changes only on a successful commit.

---
 rtl/rll_key_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/rll_key_loader.sv
// Serial key loader for the RLL16 locked core: LSB-first key bits plus one even-parity bit.
// The key is committed atomically to key_q so the core never sees a partially shifted key.
//   state  | meaning
//   IDLE   | waiting for the first key bit of a frame
//   SHIFT  | collecting key bits, then the parity bit; idle timer running
//   CHECK  | one cycle: parity verdict, commit or error
//   LOCKED | key committed with WRITE_ONCE set; ignores input until reset
module rll_key_loader #(
  parameter int               KEY_W       = 16,
  parameter logic [KEY_W-1:0] RST_KEY     = '0,
  parameter int               TIMEOUT_CYC = 64,
  parameter bit               WRITE_ONCE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             s_abort,
  output logic [KEY_W-1:0] key_q,
  output logic             key_loaded,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] idle_tmr;
  logic [KEY_W-1:0] sh;
  logic             par;
  logic             xfer;

  assign s_ready = (state == IDLE) || (state == SHIFT);
  assign xfer    = s_valid && s_ready;

  // Bits enter at the MSB and move down, so after KEY_W shifts sh[i] holds key bit i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_q      <= RST_KEY;
      key_loaded <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      cnt        <= '0;
      idle_tmr   <= '0;
      sh         <= '0;
      par        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            sh       <= {s_data, sh[KEY_W-1:1]};
            cnt      <= CNT_W'(1);
            idle_tmr <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (s_abort) begin
            cnt      <= '0;
            idle_tmr <= '0;
            state    <= IDLE;
          end else if (xfer) begin
            idle_tmr <= '0;
            if (cnt == CNT_FULL) begin
              par   <= s_data;
              state <= CHECK;
            end else begin
              sh  <= {s_data, sh[KEY_W-1:1]};
              cnt <= cnt + 1'b1;
            end
          end else if (idle_tmr == TMR_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            cnt      <= '0;
            idle_tmr <= '0;
            state    <= IDLE;
          end else begin
            idle_tmr <= idle_tmr + 1'b1;
          end
        end
        CHECK: begin
          cnt <= '0;
          if (^{sh, par} == 1'b0) begin
            key_q      <= sh;
            key_loaded <= 1'b1;
            done       <= 1'b1;
            state      <= WRITE_ONCE ? LOCKED : IDLE;
          end else begin
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= IDLE;
          end
        end
        LOCKED: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
